// File: rtl/board_draw_ctrl.sv
// ============================================================================
// board_draw_ctrl : sequences VGA pixel writes for the 4x5 game board.
// Optional macro GRID_LINES_EN draws each square's outer pixel ring white.
// Revision: 1.0
// ============================================================================
`default_nettype none

module board_draw_ctrl #(
  parameter int COLS    = 4,
  parameter int ROWS    = 5,
  parameter int SQ_SIZE = 16,
  parameter int X0      = 48,
  parameter int Y0      = 20
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [COLS*ROWS-1:0] blue_i,
  input  logic [COLS*ROWS-1:0] red_i,
  output logic [7:0]           x_o,
  output logic [6:0]           y_o,
  output logic [2:0]           colour_o,
  output logic                 plot_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int c_NSQ = COLS * ROWS;
  localparam int c_SQW = $clog2(c_NSQ);
  localparam int c_PW  = $clog2(SQ_SIZE);
  localparam logic [c_SQW-1:0] c_SQ_LAST = c_SQW'(c_NSQ - 1);
  localparam logic [c_PW-1:0]  c_P_LAST  = c_PW'(SQ_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DRAW = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [c_NSQ-1:0] snap_blue_q;
  logic [c_NSQ-1:0] snap_red_q;
  logic             pend_q;
  logic [c_SQW-1:0] sq_q;
  logic [c_PW-1:0]  px_q;
  logic [c_PW-1:0]  py_q;
  logic [7:0]       x_q;
  logic [6:0]       y_q;
  logic [2:0]       colour_q;
  logic             plot_q;
  logic             busy_q;
  logic             done_q;

  logic [8:0]       col_d;
  logic [8:0]       row_d;
  logic [7:0]       x_d;
  logic [6:0]       y_d;
  logic [2:0]       colour_d;
  logic             chg_d;

  assign chg_d = ({blue_i, red_i} != {snap_blue_q, snap_red_q});

  // Pixel address is formed in 9 bits; legal parameters keep it in range.
  always_comb begin
    col_d = 9'(sq_q) % 9'(COLS);
    row_d = 9'(sq_q) / 9'(COLS);
    x_d   = 8'(9'(X0) + col_d * 9'(SQ_SIZE) + 9'(px_q));
    y_d   = 7'(9'(Y0) + row_d * 9'(SQ_SIZE) + 9'(py_q));
    case ({snap_blue_q[sq_q], snap_red_q[sq_q]})
      2'b11:   colour_d = 3'b101;
      2'b10:   colour_d = 3'b001;
      2'b01:   colour_d = 3'b100;
      default: colour_d = 3'b000;
    endcase
`ifdef GRID_LINES_EN
    if (px_q == '0 || px_q == c_P_LAST || py_q == '0 || py_q == c_P_LAST) begin
      colour_d = 3'b111;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      snap_blue_q <= '0;
      snap_red_q  <= '0;
      pend_q      <= 1'b0;
      sq_q        <= '0;
      px_q        <= '0;
      py_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      colour_q    <= '0;
      plot_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      plot_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i || pend_q || chg_d) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          snap_blue_q <= blue_i;
          snap_red_q  <= red_i;
          sq_q        <= '0;
          px_q        <= '0;
          py_q        <= '0;
          // The board is captured now, so only a new start counts as pending.
          pend_q      <= start_i;
          state_q     <= S_DRAW;
        end
        S_DRAW: begin
          plot_q   <= 1'b1;
          x_q      <= x_d;
          y_q      <= y_d;
          colour_q <= colour_d;
          if (start_i || chg_d) pend_q <= 1'b1;
          if (px_q == c_P_LAST) begin
            px_q <= '0;
            if (py_q == c_P_LAST) begin
              py_q <= '0;
              if (sq_q == c_SQ_LAST) state_q <= S_DONE;
              else                   sq_q    <= sq_q + 1'b1;
            end else begin
              py_q <= py_q + 1'b1;
            end
          end else begin
            px_q <= px_q + 1'b1;
          end
        end
        default: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (start_i || chg_d) pend_q <= 1'b1;
        end
      endcase
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign colour_o = colour_q;
  assign plot_o   = plot_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_board_draw_ctrl.sv
// ============================================================================
// tb_board_draw_ctrl : scoreboard bench for board_draw_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_board_draw_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [19:0] blue;
  logic [19:0] red;
  logic [7:0]  x_o;
  logic [6:0]  y_o;
  logic [2:0]  colour_o;
  logic        plot_o;
  logic        busy_o;
  logic        done_o;

  board_draw_ctrl dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .start_i  (start),
    .blue_i   (blue),
    .red_i    (red),
    .x_o      (x_o),
    .y_o      (y_o),
    .colour_o (colour_o),
    .plot_o   (plot_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [17:0] exp_q[$];
  int  run            = 0;
  int  last_run       = 0;
  int  done_cnt       = 0;
  int  done_cyc       = 0;
  int  first_plot_cyc = 0;
  bit  prev_plot      = 1'b0;
  int  t0             = 0;

  task automatic check(input string nm, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endtask

  // Expected frame: every square in index order, rows of pixels within it.
  task automatic push_frame(input logic [19:0] b, input logic [19:0] r);
    for (int sq = 0; sq < 20; sq++) begin
      for (int py = 0; py < 16; py++) begin
        for (int px = 0; px < 16; px++) begin
          int xx = 48 + (sq % 4) * 16 + px;
          int yy = 20 + (sq / 4) * 16 + py;
          logic [2:0] c;
          if (b[sq] && r[sq]) c = 3'b101;
          else if (b[sq])     c = 3'b001;
          else if (r[sq])     c = 3'b100;
          else                c = 3'b000;
`ifdef GRID_LINES_EN
          if (px == 0 || px == 15 || py == 0 || py == 15) c = 3'b111;
`endif
          exp_q.push_back({8'(xx), 7'(yy), c});
        end
      end
    end
  endtask

  // Monitor: pops the scoreboard on every plot strobe, checks frame framing on done.
  always @(negedge clk) begin
    if (reset) begin
      run       = 0;
      prev_plot = 1'b0;
    end else begin
      if (plot_o) begin
        logic [17:0] e;
        if (!prev_plot) first_plot_cyc = cyc;
        run++;
        check("busy_during_plot", int'(busy_o), 1);
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_plot: actual x=%0d y=%0d c=%0d required no plot",
                   x_o, y_o, colour_o);
        end else begin
          e = exp_q.pop_front();
          if ({x_o, y_o, colour_o} !== e) begin
            n_fail++;
            $display("FAIL pixel: actual x=%0d y=%0d c=%0d required x=%0d y=%0d c=%0d",
                     x_o, y_o, colour_o, e[17:10], e[9:3], e[2:0]);
          end
        end
      end else if (prev_plot) begin
        last_run = run;
        run      = 0;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", int'(busy_o), 0);
        check("plot_run_length", last_run, 5120);
      end
      prev_plot = plot_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == d0) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: actual no done required done within %0d cycles", budget);
    end
  endtask

  task automatic redraw(input logic [19:0] b, input logic [19:0] r);
    blue  = b;
    red   = r;
    start = 1'b1;
    t0    = cyc;
    push_frame(b, r);
    tick();
    start = 1'b0;
    wait_done(6000);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: actual simulation still running required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [19:0] b;
    logic [19:0] r;
    int d;
    int n;
    reset = 1'b1;
    start = 1'b0;
    blue  = '0;
    red   = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_x",      int'(x_o), 0);
    check("reset_y",      int'(y_o), 0);
    check("reset_colour", int'(colour_o), 0);
    check("reset_plot",   int'(plot_o), 0);
    check("reset_busy",   int'(busy_o), 0);
    check("reset_done",   int'(done_o), 0);
    repeat (2) tick();

    // Empty board with latency checks.
    redraw(20'h0, 20'h0);
    check("first_plot_latency", first_plot_cyc - t0, 3);
    check("done_latency",       done_cyc - t0, 5123);
    tick();

    redraw(20'h00001, 20'h00020);
    tick();

    // Auto-redraw from a board change alone.
    blue = 20'h80001;
    t0   = cyc;
    push_frame(20'h80001, 20'h00020);
    tick();
    check("busy_after_accept", int'(busy_o), 1);
    wait_done(6000);
    check("auto_first_plot_latency", first_plot_cyc - t0, 3);
    tick();

    // Events while busy collapse into exactly one extra redraw using new inputs.
    b = 20'($urandom);
    r = 20'($urandom) & ~b;
    d = done_cnt;
    blue  = b;
    red   = r;
    start = 1'b1;
    push_frame(b, r);
    tick();
    start = 1'b0;
    repeat (100) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    red = r ^ 20'h0F0F0;
    push_frame(b, r ^ 20'h0F0F0);
    repeat (50) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(6000);
    wait_done(6000);
    repeat (30) tick();
    check("pending_redraw_count", done_cnt - d, 2);

    // Reset mid-redraw aborts cleanly.
    blue  = '0;
    red   = '0;
    start = 1'b1;
    push_frame(20'h0, 20'h0);
    tick();
    start = 1'b0;
    n = 0;
    while (run < 1000 && n < 2000) begin
      tick();
      n++;
    end
    check("reached_pixel_1000", int'(run >= 1000), 1);
    reset = 1'b1;
    exp_q.delete();
    d = done_cnt;
    tick();
    reset = 1'b0;
    check("abort_plot", int'(plot_o), 0);
    check("abort_busy", int'(busy_o), 0);
    check("abort_done", int'(done_o), 0);
    repeat (20) tick();
    check("abort_no_done", done_cnt - d, 0);
    redraw(20'($urandom), 20'($urandom));
    tick();

    redraw(20'hFFFFF, 20'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      redraw(20'($urandom), 20'($urandom));
      tick();
    end

    repeat (10) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
